// File: rtl/lsu_mem_ctrl.sv
// Load/store unit driving a word-wide data memory: sign/zero-extended loads and
// read-modify-write sub-word stores. Define MISALIGN_TRAP_EN to reject misaligned halfword/word accesses.
module lsu_mem_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE,
        RMW_RD,
        RMW_WR,
        RESP
    } state_t;

    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(4 * MEM_WORDS);

    state_t      state;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;

    logic        funct3_ok;
    logic        addr_ok;
    logic        misalign;
    logic        req_err;

    assign req_ready = (state == IDLE) && !rst;

    // Request screening: anything rejected here goes straight to RESP without touching memory.
    always_comb begin
        funct3_ok = 1'b0;
        misalign  = 1'b0;
        if (req_write) begin
            funct3_ok = (req_funct3 <= 3'd2);
        end else begin
            case (req_funct3)
                3'd0, 3'd1, 3'd2, 3'd4, 3'd5: funct3_ok = 1'b1;
                default:                      funct3_ok = 1'b0;
            endcase
        end
        addr_ok = ({1'b0, req_addr} < ADDR_LIMIT);
`ifdef MISALIGN_TRAP_EN
        if (req_funct3[1:0] == 2'd1) begin
            misalign = req_addr[0];
        end else if (req_funct3[1:0] == 2'd2) begin
            misalign = (req_addr[1:0] != 2'd0);
        end
`else
        misalign = 1'b0;
`endif
        req_err = !funct3_ok || !addr_ok || misalign;
    end

    function automatic logic [31:0] extend_load(input logic [2:0]  f3,
                                                input logic [1:0]  lane,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd4:    return {24'd0, b};
            3'd5:    return {16'd0, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] merge_store(input logic [2:0]  f3,
                                                input logic [1:0]  lane,
                                                input logic [31:0] old_word,
                                                input logic [15:0] wd);
        logic [31:0] w;
        w = old_word;
        if (f3[1:0] == 2'd0) begin
            case (lane)
                2'd0:    w[7:0]   = wd[7:0];
                2'd1:    w[15:8]  = wd[7:0];
                2'd2:    w[23:16] = wd[7:0];
                default: w[31:24] = wd[7:0];
            endcase
        end else if (lane[1]) begin
            w[31:16] = wd;
        end else begin
            w[15:0] = wd;
        end
        return w;
    endfunction

    // Single sequencer; every memory/response output is registered so it lines up with its state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            funct3_q   <= 3'd0;
            lane_q     <= 2'd0;
            wdata_q    <= 16'd0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_wdata  <= 32'd0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        funct3_q   <= req_funct3;
                        lane_q     <= req_addr[1:0];
                        wdata_q    <= req_wdata[15:0];
                        mem_addr   <= {req_addr[ADDR_W-1:2], 2'b00};
                        resp_rdata <= 32'd0;
                        if (req_err) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            state      <= RESP;
                        end else if (!req_write) begin
                            mem_read <= 1'b1;
                            state    <= LOAD;
                        end else if (req_funct3[1:0] == 2'd2) begin
                            mem_write <= 1'b1;
                            mem_wdata <= req_wdata;
                            state     <= STORE;
                        end else begin
                            mem_read <= 1'b1;
                            state    <= RMW_RD;
                        end
                    end
                end
                LOAD: begin
                    resp_rdata <= extend_load(funct3_q, lane_q, mem_rdata);
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                STORE: begin
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RMW_RD: begin
                    mem_write <= 1'b1;
                    mem_wdata <= merge_store(funct3_q, lane_q, mem_rdata, wdata_q);
                    state     <= RMW_WR;
                end
                RMW_WR: begin
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    resp_rdata <= 32'd0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read and write strobes share one memory port and must never overlap.
    assert property (@(posedge clk) disable iff (rst) !(mem_read && mem_write));
    assert property (@(posedge clk) disable iff (rst) resp_valid |=> !resp_valid);

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: a byte-level reference memory predicts every
// response, which is checked when resp_valid fires, along with latency and memory side effects.
module tb_lsu_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          accept_cycle;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] dmem [0:255];
    logic [7:0]  ref_mem [0:1023];
    int          cycle;
    int          write_count;
    int          read_count;
    int          overlap_count;
    int          wdata_leak;
    int          check_count;
    int          fail_count;

    lsu_mem_ctrl #(.ADDR_W(32), .MEM_WORDS(256)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = (mem_addr < 32'd1024) ? dmem[mem_addr[9:2]] : 32'd0;

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (mem_write && mem_addr < 32'd1024) dmem[mem_addr[9:2]] <= mem_wdata;
        if (mem_write) write_count <= write_count + 1;
        if (mem_read) read_count <= read_count + 1;
        if (mem_read && mem_write) overlap_count <= overlap_count + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Response monitor: pops the oldest prediction whenever the DUT completes a request.
    always @(negedge clk) begin
        if (!mem_write && mem_wdata != 32'd0) wdata_leak++;
        if (resp_valid) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("resp_rdata", resp_rdata, e.rdata);
                checkOutput("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                checkOutput("resp_latency", 32'(cycle - e.accept_cycle), 32'(e.lat));
            end
        end
    end

    function automatic logic [31:0] ref_word(input int base);
        return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
    endfunction

    // Reference behaviour at byte granularity; also commits stores to the reference memory.
    task automatic modelReq(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, output exp_t e);
        logic legal;
        int   idx;
        logic [7:0]  b;
        logic [15:0] h;
        e.rdata = 32'd0;
        e.err   = 1'b0;
        e.lat   = 1;
        e.accept_cycle = 0;
        if (wr) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        else    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (!legal || a >= 32'd1024) e.err = 1'b1;
`ifdef MISALIGN_TRAP_EN
        if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) e.err = 1'b1;
        if (f3 == 3'd2 && (a % 4) != 0) e.err = 1'b1;
`endif
        if (e.err) return;
        idx = int'(a[9:0]);
        if (!wr) begin
            e.lat = 2;
            b = ref_mem[idx];
            h = {ref_mem[(idx & ~1) + 1], ref_mem[idx & ~1]};
            case (f3)
                3'd0:    e.rdata = {{24{b[7]}}, b};
                3'd4:    e.rdata = {24'd0, b};
                3'd1:    e.rdata = {{16{h[15]}}, h};
                3'd5:    e.rdata = {16'd0, h};
                default: e.rdata = ref_word(idx & ~3);
            endcase
        end else begin
            case (f3)
                3'd0: begin
                    ref_mem[idx] = wd[7:0];
                    e.lat = 3;
                end
                3'd1: begin
                    ref_mem[idx & ~1]       = wd[7:0];
                    ref_mem[(idx & ~1) + 1] = wd[15:8];
                    e.lat = 3;
                end
                default: begin
                    for (int k = 0; k < 4; k++) ref_mem[(idx & ~3) + k] = wd[8*k +: 8];
                    e.lat = 2;
                end
            endcase
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd);
        exp_t e;
        int   waited;
        modelReq(wr, f3, a, wd, e);
        @(negedge clk);
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        e.accept_cycle = cycle;
        sb_q.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
        waited = 0;
        while (sb_q.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (sb_q.size() != 0) begin
            checkOutput("resp_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
    endtask

    initial begin
        int          wc;
        int          rc;
        logic [31:0] saved;
        logic        wr;
        logic [2:0]  f3;

        check_count = 0;
        fail_count  = 0;
        cycle = 0;
        write_count = 0;
        read_count = 0;
        overlap_count = 0;
        wdata_leak = 0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_funct3 = 3'd0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        for (int i = 0; i < 256; i++) begin
            saved = $urandom;
            dmem[i] = saved;
            for (int k = 0; k < 4; k++) ref_mem[4*i + k] = saved[8*k +: 8];
        end

        rst = 1'b1;
        #12;
        checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd0);
        checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("rst_mem_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_req_ready", {31'd0, req_ready}, 32'd1);

        // Word store then load back.
        wc = write_count;
        applyStimulus(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        checkOutput("sw_write_pulses", 32'(write_count - wc), 32'd1);
        applyStimulus(1'b0, 3'd2, 32'h10, 32'd0);

        // Byte store via read-modify-write.
        applyStimulus(1'b1, 3'd2, 32'h10, 32'h11223344);
        wc = write_count;
        rc = read_count;
        applyStimulus(1'b1, 3'd0, 32'h12, 32'h000000AA);
        checkOutput("sb_mem_word", dmem[4], 32'h11AA3344);
        checkOutput("sb_write_pulses", 32'(write_count - wc), 32'd1);
        checkOutput("sb_read_pulses", 32'(read_count - rc), 32'd1);
        applyStimulus(1'b0, 3'd2, 32'h10, 32'd0);

        // Sign and zero extension on each lane width.
        applyStimulus(1'b1, 3'd2, 32'h20, 32'h80F0007F);
        applyStimulus(1'b0, 3'd0, 32'h23, 32'd0);
        applyStimulus(1'b0, 3'd4, 32'h23, 32'd0);
        applyStimulus(1'b0, 3'd1, 32'h22, 32'd0);
        applyStimulus(1'b0, 3'd5, 32'h20, 32'd0);
        applyStimulus(1'b1, 3'd1, 32'h22, 32'h0000BEEF);
        checkOutput("sh_mem_word", dmem[8], 32'hBEEF007F);

        // Rejected requests perform no access.
        rc = read_count;
        wc = write_count;
        applyStimulus(1'b0, 3'd2, 32'h401, 32'd0);
        applyStimulus(1'b0, 3'd3, 32'h10, 32'd0);
        applyStimulus(1'b1, 3'd5, 32'h10, 32'h12345678);
        applyStimulus(1'b1, 3'd0, 32'h400, 32'h12345678);
        checkOutput("err_no_read", 32'(read_count - rc), 32'd0);
        checkOutput("err_no_write", 32'(write_count - wc), 32'd0);
        applyStimulus(1'b0, 3'd2, 32'h3FC, 32'd0);

        // Misaligned word load: trap or aligned fallback depending on build.
        rc = read_count;
        applyStimulus(1'b0, 3'd2, 32'h12, 32'd0);
`ifdef MISALIGN_TRAP_EN
        checkOutput("misalign_reads", 32'(read_count - rc), 32'd0);
`else
        checkOutput("misalign_reads", 32'(read_count - rc), 32'd1);
`endif
        applyStimulus(1'b0, 3'd5, 32'h23, 32'd0);

        for (int n = 0; n < 40; n++) begin
            wr = 1'($urandom_range(0, 1));
            if (wr) f3 = 3'($urandom_range(0, 2));
            else begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 == 3'd3) f3 = 3'd5;
            end
            applyStimulus(wr, f3, 32'($urandom_range(0, 63)), $urandom);
        end

        // Abort a byte store during its read phase.
        saved = dmem[4];
        wc = write_count;
        @(negedge clk);
        req_write = 1'b1;
        req_funct3 = 3'd0;
        req_addr = 32'h12;
        req_wdata = 32'h55;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checkOutput("rmw_rd_mem_read", {31'd0, mem_read}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("abort_mem_read", {31'd0, mem_read}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("abort_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("abort_no_write", 32'(write_count - wc), 32'd0);
        checkOutput("abort_mem_word", dmem[4], saved);
        applyStimulus(1'b0, 3'd2, 32'h10, 32'd0);

        checkOutput("rw_overlap", 32'(overlap_count), 32'd0);
        checkOutput("wdata_idle_zero", 32'(wdata_leak), 32'd0);
        checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
